// File: rtl/fp_i2f.sv
// Multi-cycle 32-bit integer to IEEE-754 single-precision converter.
// Shares the start/done handshake and one-bit-per-cycle normalisation of the FP adder.
module fp_i2f #(
  parameter int unsigned SIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] sum,
  output logic        done,
  output logic        busy
);

  localparam int unsigned INT_W     = 32;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MANT_W    = 23;
  localparam int unsigned EXP_BIAS  = 127;
  localparam int unsigned GUARD_BIT = INT_W - MANT_W - 2;
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + INT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_PACK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [INT_W-1:0]    mag_q, mag_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic                sign_q, sign_d;
  logic                zero_q, zero_d;
  logic [INT_W-1:0]    sum_q, sum_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                start_sign;
  logic [MANT_W-1:0]   mant_trunc;
  logic                guard;
  logic                sticky;
  logic                round_up;

  assign start_sign = (SIGNED != 0) && a[INT_W-1];
  assign mant_trunc = mag_q[INT_W-2 -: MANT_W];
  assign guard      = mag_q[GUARD_BIT];
  assign sticky     = |mag_q[GUARD_BIT-1:0];
  // Round-to-nearest-even: ties go up only when the kept LSB is odd.
  assign round_up   = guard & (sticky | mant_trunc[0]);

  // Next-state and datapath update; a start pulse overrides whatever is in flight.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    sum_d   = sum_q;
    done_d  = done_q;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
      end
      S_NORM: begin
        if (!mag_q[INT_W-1]) begin
          mag_d = {mag_q[INT_W-2:0], 1'b0};
          exp_d = exp_q - EXP_W'(1);
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        mant_d = mant_trunc;
        if (round_up) begin
          if (&mant_trunc) begin
            mant_d = '0;
            exp_d  = exp_q + EXP_W'(1);
          end else begin
            mant_d = mant_trunc + MANT_W'(1);
          end
        end
        state_d = S_PACK;
      end
      S_PACK: begin
        sum_d   = zero_q ? '0 : {sign_q, exp_q, mant_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start) begin
      done_d  = 1'b0;
      busy_d  = 1'b1;
      sign_d  = start_sign;
      // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
      mag_d   = start_sign ? (~a + INT_W'(1)) : a;
      exp_d   = EXP_TOP;
      zero_d  = (a == '0);
      state_d = (a == '0) ? S_PACK : S_NORM;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign sum  = sum_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fp_i2f.sv
// Bench for fp_i2f: signed and unsigned instances share stimulus and are checked
// every cycle against an arithmetic conversion/latency model plus literal vectors.
module tb_fp_i2f;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] sum_s, sum_u;
  logic        done_s, done_u;
  logic        busy_s, busy_u;

  int total  = 0;
  int passed = 0;

  fp_i2f #(.SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .start(start), .a(a),
    .sum(sum_s), .done(done_s), .busy(busy_s)
  );

  fp_i2f #(.SIGNED(0)) u_dut_u (
    .clk(clk), .reset(reset), .start(start), .a(a),
    .sum(sum_u), .done(done_u), .busy(busy_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
    else passed++;
  endtask

  // Magnitude of the operand as a mathematical value.
  function automatic logic [63:0] mag_of(input logic [31:0] v, input bit sgn);
    logic [63:0] m;
    m = {32'd0, v};
    if (sgn && v[31]) m = 64'h1_0000_0000 - m;
    return m;
  endfunction

  function automatic int msb_of(input logic [63:0] m);
    int p;
    p = -1;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    return p;
  endfunction

  // Integer -> float by value: scale to 24 significant bits, round half to even.
  function automatic logic [31:0] fmodel(input logic [31:0] v, input bit sgn);
    logic [63:0] m, q, rem, half;
    int p, sh;
    m = mag_of(v, sgn);
    if (m == 0) return 32'h0;
    p = msb_of(m);
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == 64'h100_0000) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    return {sgn && v[31], 8'(127 + p), q[22:0]};
  endfunction

  // Cycles from the sampling edge to the edge after which done is high.
  function automatic int flat(input logic [31:0] v, input bit sgn);
    logic [63:0] m;
    m = mag_of(v, sgn);
    if (m == 0) return 1;
    return (31 - msb_of(m)) + 3;
  endfunction

  // Cycle-level expectation: index 0 = signed instance, 1 = unsigned instance.
  int          cnt    [2];
  logic [31:0] pend   [2];
  logic [31:0] m_sum  [2];
  logic        m_done [2];
  logic        m_busy [2];

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        cnt[k]    <= 0;
        pend[k]   <= '0;
        m_sum[k]  <= '0;
        m_done[k] <= 1'b0;
        m_busy[k] <= 1'b0;
      end else if (start) begin
        cnt[k]    <= flat(a, k == 0);
        pend[k]   <= fmodel(a, k == 0);
        m_done[k] <= 1'b0;
        m_busy[k] <= 1'b1;
      end else if (cnt[k] != 0) begin
        cnt[k] <= cnt[k] - 1;
        if (cnt[k] == 1) begin
          m_sum[k]  <= pend[k];
          m_done[k] <= 1'b1;
          m_busy[k] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_sum_s",  sum_s,         m_sum[0]);
    chk("cyc_done_s", 32'(done_s),   32'(m_done[0]));
    chk("cyc_busy_s", 32'(busy_s),   32'(m_busy[0]));
    chk("cyc_sum_u",  sum_u,         m_sum[1]);
    chk("cyc_done_u", 32'(done_u),   32'(m_done[1]));
    chk("cyc_busy_u", 32'(busy_u),   32'(m_busy[1]));
  end

  // Called at a falling edge; the operand is sampled at the next rising edge (E0).
  task automatic pulse_start(input logic [31:0] val);
    a     = val;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_done_clr_s", 32'(done_s), 32'd0);
    chk("start_busy_s",     32'(busy_s), 32'd1);
  endtask

  task automatic wait_both(input string name, input int lat_s, input logic [31:0] exp_s,
                           input int lat_u, input logic [31:0] exp_u);
    int n, ls, lu;
    n  = 0;
    ls = -1;
    lu = -1;
    while ((ls < 0 || lu < 0) && n < 60) begin
      @(negedge clk);
      n++;
      if (done_s && ls < 0) ls = n;
      if (done_u && lu < 0) lu = n;
    end
    chk({name, "_lat_s"}, 32'(ls), 32'(lat_s));
    chk({name, "_lat_u"}, 32'(lu), 32'(lat_u));
    chk({name, "_sum_s"}, sum_s, exp_s);
    chk({name, "_sum_u"}, sum_u, exp_u);
  endtask

  task automatic conv(input string name, input logic [31:0] val,
                      input logic [31:0] exp_s, input int lat_s,
                      input logic [31:0] exp_u, input int lat_u);
    chk({name, "_model_s"}, fmodel(val, 1'b1), exp_s);
    chk({name, "_model_u"}, fmodel(val, 1'b0), exp_u);
    pulse_start(val);
    wait_both(name, lat_s, exp_s, lat_u, exp_u);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b0;
    a     = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum",  sum_s,        32'h0);
    chk("rst_done", 32'(done_s),  32'd0);
    chk("rst_busy", 32'(busy_s),  32'd0);
    reset = 1'b1;
    @(negedge clk);

    conv("one",      32'd1,        32'h3F80_0000, 34, 32'h3F80_0000, 34);
    conv("minus1",   32'hFFFF_FFFF, 32'hBF80_0000, 34, 32'h4F80_0000, 3);
    conv("intmin",   32'h8000_0000, 32'hCF00_0000, 3,  32'h4F00_0000, 3);
    conv("zero",     32'd0,        32'h0000_0000, 1,  32'h0000_0000, 1);
    conv("tie_even", 32'd16777217, 32'h4B80_0000, 10, 32'h4B80_0000, 10);
    conv("tie_up",   32'd16777219, 32'h4B80_0002, 10, 32'h4B80_0002, 10);
    conv("carry",    32'h7FFF_FFFF, 32'h4F00_0000, 4,  32'h4F00_0000, 4);
    conv("k1000",    32'd1000,     32'h447A_0000, 25, 32'h447A_0000, 25);
    conv("m1000",    32'hFFFF_FC18, 32'hC47A_0000, 25, 32'h4F7F_FFFC, 3);

    // Restart mid-conversion: first operand must never produce done.
    pulse_start(32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("restart_no_done", 32'(done_s), 32'd0);
    end
    pulse_start(32'hFFFF_FFFE);
    wait_both("restart", 33, 32'hC000_0000, 3, 32'h4F80_0000);

    // Asynchronous reset while normalising.
    pulse_start(32'd5);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_sum",  sum_s,       32'h0);
    chk("arst_done", 32'(done_s), 32'd0);
    chk("arst_busy", 32'(busy_s), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_sum",  sum_s,       32'h0);
    chk("post_rst_done", 32'(done_s), 32'd0);
    chk("post_rst_busy", 32'(busy_s), 32'd0);

    conv("recover", 32'd3, 32'h4040_0000, 33, 32'h4040_0000, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_i2f.md
Name: fp_i2f

Overview:
- Multi-cycle converter from a 32-bit integer to an IEEE-754 single-precision value.
- It is the encode-side counterpart to the floating-point adder: it produces packed floats that the adder consumes.
- It uses the same start/done handshake and the same one-bit-per-cycle normalisation style.
- Intended use: feeding integer counts or accumulator values into the FP datapath.

Parameters:
- SIGNED, 1: 1 = input `a` is two's-complement signed; 0 = input `a` is unsigned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; samples `a` and begins a conversion (always accepted, including mid-operation).
- a  input  32  integer operand.
- sum  output  32  packed result {sign, exp[7:0], mant[22:0]}.
- done  output  1  high while `sum` holds a valid result.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, sum=0, done=0, busy=0; internal registers cleared.
- Reset mid-operation aborts the conversion with no result.
- States: IDLE, NORM, ROUND, PACK, DONE.
- start sampled high (edge E0), from any state:
  - done<=0, busy<=1.
  - sign<=(SIGNED & a[31]).
  - mag[31:0]<=sign ? -a : a. For a=0x80000000 signed, mag=0x80000000 unsigned.
  - exp<=158 (127+31).
  - If a==0: zero flag set, go to PACK. Otherwise go to NORM.
- NORM:
  - If mag[31]==0: mag<=mag<<1, exp<=exp-1, stay in NORM.
  - Else go to ROUND.
  - At most 31 shift cycles.
- ROUND (round-to-nearest-even):
  - mant=mag[30:8], guard=mag[7], sticky=|mag[6:0].
  - Round up when guard & (sticky | mant[0]).
  - If mant==all ones and rounding up: mant<=0, exp<=exp+1.
  - Go to PACK.
- PACK:
  - sum<=zero ? 32'h0 : {sign, exp, mant}.
  - done<=1, busy<=0, go to DONE.
- DONE: hold sum and done until the next start.
- IDLE: hold sum and done.
- Latency, with lz = leading zeros of mag:
  - Nonzero input: done rises after edge E(lz+3), so 3 to 34 cycles.
  - Zero input: done rises after E1.
- No overflow or inf/NaN is possible; the maximum exponent is 159.
- Zero always encodes +0 (0x00000000).
- start while busy: the old conversion is discarded, the new operand is captured at the same edge, and done stays 0 until the new result is ready.
- sum is only updated in PACK. The previous result stays visible (with done=0) during a new conversion.

Test Plan:
- SIGNED=1, a=1 -> sum=0x3F800000, done after E34. a=-1 -> sum=0xBF800000.
- SIGNED=1, a=0x80000000 -> sum=0xCF000000, done after E3. a=0 -> sum=0x00000000, done after E1.
- Rounding:
  - a=16777217 -> 0x4B800000 (tie, round to even).
  - a=16777219 -> 0x4B800002 (tie, round up).
  - a=0x7FFFFFFF -> 0x4F000000 (mantissa carry bumps exp).
- SIGNED=0, a=0xFFFFFFFF -> 0x4F800000. Same parameter, a=0x80000000 -> 0x4F000000.
- Restart: start with a=1, then start again with a=-2 three cycles later -> done never pulses for the first operand; sum=0xC0000000, done after E33 of the second start.
- Reset mid-operation: assert reset=0 during NORM -> sum=0, done=0, busy=0 immediately (asynchronous); after release with no start, the outputs stay at those values.
